bps_exec_unit: RTL and testbench
================================

// Module: bps_exec_unit
// PURPOSE
//   Executes opcodes issued by the BP-S master. Each opcode is one multi-cycle job: load node data
//   from memory, run a downward or upward sweep through the PE array, or store node data back.
//   Holds bps_stall high until the job completes.
//   Sits between the master and the node buffer, memory ports and PE array.
// PARAMETERS
//   N_NODES   256  nodes per job; power of two, >=2 (IDX_W = clog2(N_NODES), localparam)
//   ADDR_W    16   memory word-address width
//   DATA_W    32   node data word width
// PORTS
//   clk           in   1       clock
//   rst           in   1       reset, synchronous, active-high
//   bps_opcode    in   3       0 idle,1 LOAD,2 DOWN,3 UP,4 STORE_DOWN,5 STORE_UP; 6,7 illegal
//   bps_stall     out  1       job in progress
//   base_addr     in   ADDR_W  memory base; sampled on opcode accept
//   mem_rd_req    out  1       read request; held until mem_rd_gnt
//   mem_rd_addr   out  ADDR_W  read address
//   mem_rd_gnt    in   1       read request accepted this cycle
//   mem_rd_valid  in   1       read response (in request order)
//   mem_rd_data   in   DATA_W  read response data
//   mem_wr_req    out  1       write request; held until mem_wr_gnt
//   mem_wr_addr   out  ADDR_W  write address
//   mem_wr_data   out  DATA_W  write data
//   mem_wr_gnt    in   1       write accepted this cycle
//   buf_we        out  1       node buffer write strobe
//   buf_waddr     out  IDX_W   node buffer write index
//   buf_wdata     out  DATA_W  node buffer write data
//   buf_re        out  1       node buffer read strobe; data valid 1 cycle later
//   buf_raddr     out  IDX_W   node buffer read index
//   buf_rdata     in   DATA_W  node buffer read data
//   pe_valid      out  1       sweep step issue; held until pe_ready
//   pe_dir        out  1       0 down, 1 up
//   pe_idx        out  IDX_W   node index of current step
//   pe_ready      in   1       PE accepted the step
//   pe_idle       in   1       PE pipeline drained
//   err_op        out  1       one-cycle pulse on illegal opcode
// BEHAVIOUR
//   - Reset: state IDLE; every output 0 and all counters 0. rst mid-job aborts immediately.
//   - After reset, mem_rd_valid is ignored until the next LOAD is accepted.
//   - bps_stall is registered. A nonzero opcode in IDLE is accepted at that clock edge.
//     bps_stall is 1 from the next cycle until the job's final cycle inclusive.
//     It falls the cycle after completion (state back in IDLE).
//   - Opcodes are ignored while not IDLE. Opcode 0 in IDLE: no action.
//   - States: IDLE, LOAD, SWEEP, DRAIN, ST_RD, ST_WR, ERR.
//   - LOAD: request counter rq 0..N-1 and response counter rs 0..N-1.
//     mem_rd_req=1 while rq<N, with mem_rd_addr=base+rq; rq increments on gnt.
//     Each mem_rd_valid writes buf_we=1, buf_waddr=rs, buf_wdata=mem_rd_data; rs increments.
//     Request and response may fire in the same cycle, including the first response on the gnt cycle.
//     Done when rs reaches N -> IDLE.
//   - DOWN/UP -> SWEEP with pe_dir=0/1. pe_idx steps 0..N-1 (down) or N-1..0 (up).
//     pe_idx advances on pe_valid&pe_ready; the last step goes to DRAIN.
//     DRAIN waits for pe_idle=1, then -> IDLE. Minimum DRAIN length is 1 cycle.
//   - STORE_DOWN/STORE_UP use offset 0 / N_NODES. Per word i (0..N-1):
//     ST_RD asserts buf_re, buf_raddr=i for 1 cycle, then ST_WR.
//     ST_WR sets mem_wr_req=1, mem_wr_addr=base+off+i, mem_wr_data=buf_rdata captured from ST_RD.
//     Data is held stable until gnt. On gnt: i=N-1 -> IDLE, else ST_RD.
//     Throughput is 1 word per 2 cycles minimum.
//   - Illegal opcode (6,7) -> ERR for 1 cycle (bps_stall=1 that cycle), err_op pulses 1 cycle, -> IDLE.
//   - Address arithmetic is modulo 2^ADDR_W (wraps). Index counters are IDX_W+1 bits, no wrap.
//   - Request outputs drop to 0 in the cycle after their final gnt.
// TESTING
//   - LOAD, base=0x0100, gnt always 1, valid 2 cycles after gnt -> 256 reqs at 0x0100..0x01FF.
//     buf writes idx 0..255 carry matching data; stall falls after the 256th valid.
//   - LOAD with random gnt/valid gaps, incl. valid on gnt cycle -> buf_waddr strictly sequential.
//     No write is lost; rs=256 at done.
//   - UP sweep, pe_ready toggling, pe_idle held 0 for 5 cycles after last step -> pe_idx 255..0 each once.
//     pe_dir=1; stall stays high until pe_idle rises.
//   - STORE_UP, base=0xFF80, N=256 -> writes wrap 0x0080..0x017F.
//     mem_wr_data = buffer contents; req held stable under gnt=0.
//   - Opcode 7 -> err_op one pulse, bps_stall high exactly 1 cycle. Opcode 2 presented while busy -> ignored.
//   - rst asserted mid-LOAD at rq=40 -> next cycle all outputs 0, stall 0. Late mem_rd_valid -> no buf_we.

Source files
------------

// File: rtl/bps_exec_unit.sv
// BP-S execution unit: runs one LOAD / sweep / STORE job per accepted opcode and holds
// bps_stall high until that job has finished.
module bps_exec_unit #(
   parameter int   N_NODES = 256,
   parameter int   ADDR_W  = 16,
   parameter int   DATA_W  = 32,
   localparam int  IDX_W   = $clog2(N_NODES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        bps_opcode,
   output logic              bps_stall,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_gnt,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic              mem_wr_gnt,
   output logic              buf_we,
   output logic [IDX_W-1:0]  buf_waddr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic              buf_re,
   output logic [IDX_W-1:0]  buf_raddr,
   input  logic [DATA_W-1:0] buf_rdata,
   output logic              pe_valid,
   output logic              pe_dir,
   output logic [IDX_W-1:0]  pe_idx,
   input  logic              pe_ready,
   input  logic              pe_idle,
   output logic              err_op
);

   localparam logic [IDX_W:0]    N_CNT    = (IDX_W+1)'(N_NODES);
   localparam logic [IDX_W:0]    LAST_CNT = (IDX_W+1)'(N_NODES - 1);
   localparam logic [IDX_W:0]    ONE_CNT  = (IDX_W+1)'(1);
   localparam logic [ADDR_W-1:0] UP_OFF   = ADDR_W'(N_NODES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SWEEP = 3'd2,
      S_DRAIN = 3'd3,
      S_ST_RD = 3'd4,
      S_ST_WR = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                stall_q, stall_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                dir_q, dir_d;
   logic                up_off_q, up_off_d;
   logic [IDX_W:0]      rq_q, rq_d;
   logic [IDX_W:0]      rs_q, rs_d;
   logic [IDX_W:0]      idx_q, idx_d;
   logic                bw_we_q, bw_we_d;
   logic [IDX_W-1:0]    bw_addr_q, bw_addr_d;
   logic [DATA_W-1:0]   bw_data_q, bw_data_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                wr_first_q, wr_first_d;
   logic                rd_req_s;
   logic                last_step_s;
   logic [ADDR_W-1:0]   off_s;

   assign rd_req_s    = (state_q == S_LOAD) && (rq_q != N_CNT);
   assign last_step_s = dir_q ? (idx_q == '0) : (idx_q == LAST_CNT);
   assign off_s       = up_off_q ? UP_OFF : '0;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      dir_d      = dir_q;
      up_off_d   = up_off_q;
      rq_d       = rq_q;
      rs_d       = rs_q;
      idx_d      = idx_q;
      bw_we_d    = 1'b0;
      bw_addr_d  = bw_addr_q;
      bw_data_d  = bw_data_q;
      wr_data_d  = wr_data_q;
      wr_first_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bps_opcode != 3'd0) begin
               base_d = base_addr;
            end else begin
               base_d = base_q;
            end
            case (bps_opcode)
               3'd1: begin
                  state_d = S_LOAD;
                  rq_d    = '0;
                  rs_d    = '0;
               end
               3'd2: begin
                  state_d = S_SWEEP;
                  dir_d   = 1'b0;
                  idx_d   = '0;
               end
               3'd3: begin
                  state_d = S_SWEEP;
                  dir_d   = 1'b1;
                  idx_d   = LAST_CNT;
               end
               3'd4: begin
                  state_d  = S_ST_RD;
                  up_off_d = 1'b0;
                  idx_d    = '0;
               end
               3'd5: begin
                  state_d  = S_ST_RD;
                  up_off_d = 1'b1;
                  idx_d    = '0;
               end
               3'd6, 3'd7: state_d = S_ERR;
               default:    state_d = S_IDLE;
            endcase
         end
         S_LOAD: begin
            // Request and response sides advance independently, possibly in the same cycle.
            if (rd_req_s && mem_rd_gnt) begin
               rq_d = rq_q + ONE_CNT;
            end else begin
               rq_d = rq_q;
            end
            if (mem_rd_valid && (rs_q != N_CNT)) begin
               bw_we_d   = 1'b1;
               bw_addr_d = rs_q[IDX_W-1:0];
               bw_data_d = mem_rd_data;
               rs_d      = rs_q + ONE_CNT;
               if (rs_q == LAST_CNT) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               rs_d = rs_q;
            end
         end
         S_SWEEP: begin
            if (pe_ready && last_step_s) begin
               state_d = S_DRAIN;
            end else if (pe_ready) begin
               idx_d = dir_q ? (idx_q - ONE_CNT) : (idx_q + ONE_CNT);
            end else begin
               idx_d = idx_q;
            end
         end
         S_DRAIN: begin
            if (pe_idle) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_ST_RD: begin
            state_d    = S_ST_WR;
            wr_first_d = 1'b1;
         end
         S_ST_WR: begin
            // buf_rdata is only valid in the first ST_WR cycle; keep a copy for gnt stalls.
            if (wr_first_q) begin
               wr_data_d = buf_rdata;
            end else begin
               wr_data_d = wr_data_q;
            end
            if (mem_wr_gnt && (idx_q == LAST_CNT)) begin
               state_d = S_IDLE;
            end else if (mem_wr_gnt) begin
               state_d = S_ST_RD;
               idx_d   = idx_q + ONE_CNT;
            end else begin
               state_d = S_ST_WR;
            end
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      stall_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         stall_q    <= 1'b0;
         base_q     <= '0;
         dir_q      <= 1'b0;
         up_off_q   <= 1'b0;
         rq_q       <= '0;
         rs_q       <= '0;
         idx_q      <= '0;
         bw_we_q    <= 1'b0;
         bw_addr_q  <= '0;
         bw_data_q  <= '0;
         wr_data_q  <= '0;
         wr_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         stall_q    <= stall_d;
         base_q     <= base_d;
         dir_q      <= dir_d;
         up_off_q   <= up_off_d;
         rq_q       <= rq_d;
         rs_q       <= rs_d;
         idx_q      <= idx_d;
         bw_we_q    <= bw_we_d;
         bw_addr_q  <= bw_addr_d;
         bw_data_q  <= bw_data_d;
         wr_data_q  <= wr_data_d;
         wr_first_q <= wr_first_d;
      end
   end

   assign bps_stall   = stall_q;
   assign mem_rd_req  = rd_req_s;
   assign mem_rd_addr = rd_req_s ? (base_q + ADDR_W'(rq_q)) : '0;
   assign mem_wr_req  = (state_q == S_ST_WR);
   assign mem_wr_addr = mem_wr_req ? (base_q + off_s + ADDR_W'(idx_q)) : '0;
   assign mem_wr_data = !mem_wr_req ? '0 : (wr_first_q ? buf_rdata : wr_data_q);
   assign buf_we      = bw_we_q;
   assign buf_waddr   = bw_addr_q;
   assign buf_wdata   = bw_data_q;
   assign buf_re      = (state_q == S_ST_RD);
   assign buf_raddr   = buf_re ? idx_q[IDX_W-1:0] : '0;
   assign pe_valid    = (state_q == S_SWEEP);
   assign pe_dir      = dir_q;
   assign pe_idx      = pe_valid ? idx_q[IDX_W-1:0] : '0;
   assign err_op      = (state_q == S_ERR);

endmodule

// File: tb/tb_bps_exec_unit.sv
// Scoreboard bench for bps_exec_unit: tests queue expected transfers, a monitor pops and
// compares them whenever the DUT shows a handshake or strobe.
module tb_bps_exec_unit;

   localparam int N  = 256;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int IW = 8;

   logic          clk;
   logic          rst;
   logic [2:0]    bps_opcode;
   logic          bps_stall;
   logic [AW-1:0] base_addr;
   logic          mem_rd_req;
   logic [AW-1:0] mem_rd_addr;
   logic          mem_rd_gnt;
   logic          mem_rd_valid;
   logic [DW-1:0] mem_rd_data;
   logic          mem_wr_req;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          mem_wr_gnt;
   logic          buf_we;
   logic [IW-1:0] buf_waddr;
   logic [DW-1:0] buf_wdata;
   logic          buf_re;
   logic [IW-1:0] buf_raddr;
   logic [DW-1:0] buf_rdata;
   logic          pe_valid;
   logic          pe_dir;
   logic [IW-1:0] pe_idx;
   logic          pe_ready;
   logic          pe_idle;
   logic          err_op;

   bps_exec_unit #(.N_NODES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .bps_opcode(bps_opcode), .bps_stall(bps_stall),
      .base_addr(base_addr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_gnt(mem_wr_gnt), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .pe_valid(pe_valid),
      .pe_dir(pe_dir), .pe_idx(pe_idx), .pe_ready(pe_ready), .pe_idle(pe_idle), .err_op(err_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int rd_gnt_cnt = 0;
   int rd_valid_cnt = 0;
   int last_valid_cyc = 0;
   int exp_err = 0;
   logic rd_rand = 1'b0;
   logic rd_first = 1'b0;
   logic wr_rand = 1'b0;

   logic [AW-1:0]      exp_rd [$];
   logic [IW+DW-1:0]   exp_bw [$];
   logic [IW:0]        exp_pe [$];
   logic [AW+DW-1:0]   exp_wr [$];
   logic [AW-1:0]      pend_addr [$];
   int                 pend_due [$];
   logic [DW-1:0]      bufmem [0:N-1];

   logic               rd_hold = 1'b0;
   logic [AW-1:0]      rd_hold_addr;
   logic               wr_hold = 1'b0;
   logic [AW+DW-1:0]   wr_hold_val;
   logic               pe_hold = 1'b0;
   logic [IW:0]        pe_hold_val;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return {a ^ 16'h5AA5, ~a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] op, input logic [AW-1:0] base);
      bps_opcode = op;
      base_addr  = base;
      step();
      bps_opcode = 3'd0;
      chk("stall_rise", {63'd0, bps_stall}, 64'd1);
   endtask

   task automatic wait_idle(input string nm, input int bound);
      int n;
      n = 0;
      while (bps_stall === 1'b1 && n < bound) begin
         step();
         n++;
      end
      chk({nm, "_done"}, {63'd0, bps_stall}, 64'd0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {63'd0, |{bps_stall, mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
                        buf_we, buf_waddr, buf_wdata, buf_re, buf_raddr, pe_valid, pe_dir,
                        pe_idx, err_op}}, 64'd0);
   endtask

   // Memory read port model: grants requests and returns data in order after a delay.
   initial begin
      mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         mem_rd_gnt   = 1'b0;
         mem_rd_valid = 1'b0;
         if (mem_rd_req === 1'b1 && (!rd_rand || $urandom_range(0, 2) != 0)) begin
            int due;
            if (!rd_rand)      due = cyc + 2;
            else if (rd_first) due = cyc;
            else               due = cyc + int'($urandom_range(0, 3));
            if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
            rd_first   = 1'b0;
            mem_rd_gnt = 1'b1;
            pend_addr.push_back(mem_rd_addr);
            pend_due.push_back(due);
            rd_gnt_cnt++;
         end
         if (pend_due.size() > 0 && pend_due[0] <= cyc && (!rd_rand || $urandom_range(0, 3) != 0)) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mdata(pend_addr.pop_front());
            void'(pend_due.pop_front());
            rd_valid_cnt++;
            last_valid_cyc = cyc;
         end
      end
   end

   // Memory write port, PE and node-buffer read models.
   initial begin
      mem_wr_gnt = 1'b0; pe_ready = 1'b0;
      forever begin
         @(negedge clk);
         mem_wr_gnt = mem_wr_req && (!wr_rand || $urandom_range(0, 2) == 0);
         pe_ready   = pe_valid && !pe_ready;
      end
   end

   initial begin
      logic          re_p;
      logic [IW-1:0] ra_p;
      buf_rdata = '0;
      forever begin
         @(negedge clk);
         re_p = buf_re;
         ra_p = buf_raddr;
         @(posedge clk);
         #1;
         buf_rdata = re_p ? bufmem[ra_p] : 32'hDEAD_BEEF;
      end
   end

   // Monitor: pops the scoreboard on every DUT transfer and checks request stability.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rd_hold) chk("rd_req_held", {47'd0, mem_rd_req, mem_rd_addr}, {47'd0, 1'b1, rd_hold_addr});
         rd_hold      = mem_rd_req && !mem_rd_gnt;
         rd_hold_addr = mem_rd_addr;
         if (mem_rd_req && mem_rd_gnt) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
            else chk("rd_addr", {48'd0, mem_rd_addr}, {48'd0, exp_rd.pop_front()});
         end
         if (buf_we) begin
            if (exp_bw.size() == 0) chk("buf_we_unexpected", 64'd1, 64'd0);
            else chk("buf_write", {24'd0, buf_waddr, buf_wdata}, {24'd0, exp_bw.pop_front()});
         end
         if (pe_hold) chk("pe_held", {54'd0, pe_valid, pe_dir, pe_idx}, {54'd0, 1'b1, pe_hold_val});
         pe_hold     = pe_valid && !pe_ready;
         pe_hold_val = {pe_dir, pe_idx};
         if (pe_valid && pe_ready) begin
            if (exp_pe.size() == 0) chk("pe_unexpected", 64'd1, 64'd0);
            else chk("pe_step", {55'd0, pe_dir, pe_idx}, {55'd0, exp_pe.pop_front()});
         end
         if (wr_hold) chk("wr_req_held", {15'd0, mem_wr_req, mem_wr_addr, mem_wr_data}, {15'd0, 1'b1, wr_hold_val});
         wr_hold     = mem_wr_req && !mem_wr_gnt;
         wr_hold_val = {mem_wr_addr, mem_wr_data};
         if (mem_wr_req && mem_wr_gnt) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
            else chk("mem_write", {16'd0, mem_wr_addr, mem_wr_data}, {16'd0, exp_wr.pop_front()});
         end
         if (err_op) begin
            chk("err_pulse", {63'd0, err_op}, {63'd0, exp_err > 0});
            if (exp_err > 0) exp_err--;
         end
      end
   end

   initial begin
      logic [AW-1:0] a;
      int n;
      int g0;
      int v0;
      rst = 1'b1; bps_opcode = 3'd0; base_addr = '0; pe_idle = 1'b1;
      for (int i = 0; i < N; i++) bufmem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      repeat (3) step();
      chk_all_zero("reset_outputs");
      rst = 1'b0;
      step();
      chk_all_zero("idle_outputs");

      // LOAD, base 0x0100, gnt always, valid two cycles after gnt
      for (int i = 0; i < N; i++) begin
         a = 16'h0100 + 16'(i);
         exp_rd.push_back(a);
         exp_bw.push_back({IW'(i), mdata(a)});
      end
      v0 = rd_valid_cnt;
      issue(3'd1, 16'h0100);
      wait_idle("load_fixed", 2000);
      chk("load_fixed_valids", 64'(rd_valid_cnt - v0), 64'd256);
      chk("load_fixed_stall_fall", 64'(cyc - last_valid_cyc), 64'd1);
      chk("load_fixed_left", 64'(exp_bw.size() + exp_rd.size()), 64'd0);

      // LOAD with random gaps, read addresses wrapping past 0xFFFF
      for (int i = 0; i < N; i++) begin
         a = 16'hFFC0 + 16'(i);
         exp_rd.push_back(a);
         exp_bw.push_back({IW'(i), mdata(a)});
      end
      rd_rand = 1'b1; rd_first = 1'b1;
      issue(3'd1, 16'hFFC0);
      wait_idle("load_rand", 5000);
      chk("load_rand_left", 64'(exp_bw.size() + exp_rd.size()), 64'd0);
      rd_rand = 1'b0;

      // DOWN sweep, pe_idle already high
      for (int i = 0; i < N; i++) exp_pe.push_back({1'b0, IW'(i)});
      issue(3'd2, 16'h0000);
      wait_idle("down", 2000);
      chk("down_left", 64'(exp_pe.size()), 64'd0);

      // UP sweep with a DOWN opcode presented mid-job and a slow drain
      pe_idle = 1'b0;
      for (int i = N - 1; i >= 0; i--) exp_pe.push_back({1'b1, IW'(i)});
      issue(3'd3, 16'h0000);
      repeat (20) step();
      bps_opcode = 3'd2;
      step();
      bps_opcode = 3'd0;
      chk("busy_opcode_stall", {63'd0, bps_stall}, 64'd1);
      n = 0;
      while (exp_pe.size() > 0 && n < 2000) begin
         step();
         n++;
      end
      chk("up_left", 64'(exp_pe.size()), 64'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("drain_stall", {63'd0, bps_stall}, 64'd1);
         chk("drain_no_valid", {63'd0, pe_valid}, 64'd0);
      end
      pe_idle = 1'b1;
      step();
      chk("drain_done", {63'd0, bps_stall}, 64'd0);

      // STORE_UP from 0xFF80: write addresses wrap to 0x0080..0x017F
      for (int i = 0; i < N; i++) begin
         a = 16'hFF80 + 16'(N) + 16'(i);
         exp_wr.push_back({a, bufmem[i]});
      end
      wr_rand = 1'b1;
      issue(3'd5, 16'hFF80);
      wait_idle("store_up", 5000);
      chk("store_up_left", 64'(exp_wr.size()), 64'd0);

      // Illegal opcode
      exp_err = 1;
      issue(3'd7, 16'h1234);
      chk("err_op_high", {63'd0, err_op}, 64'd1);
      step();
      chk("err_stall_one_cycle", {63'd0, bps_stall}, 64'd0);
      chk("err_op_low", {63'd0, err_op}, 64'd0);
      chk("err_consumed", 64'(exp_err), 64'd0);

      // Reset in the middle of a LOAD; late responses must not reach the buffer
      for (int i = 0; i < N; i++) begin
         a = 16'h2000 + 16'(i);
         exp_rd.push_back(a);
         exp_bw.push_back({IW'(i), mdata(a)});
      end
      g0 = rd_gnt_cnt;
      issue(3'd1, 16'h2000);
      n = 0;
      while (rd_gnt_cnt - g0 < 40 && n < 500) begin
         step();
         n++;
      end
      chk("rst_at_rq40", 64'(rd_gnt_cnt - g0), 64'd40);
      rst = 1'b1;
      exp_rd.delete();
      exp_bw.delete();
      step();
      chk_all_zero("mid_rst_outputs");
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("late_valid_no_we", {63'd0, buf_we}, 64'd0);
         chk("late_valid_idle", {63'd0, bps_stall}, 64'd0);
      end

      chk("final_queues", 64'(exp_rd.size() + exp_bw.size() + exp_pe.size() + exp_wr.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
